fifo_burst_rd_ctrl: RTL

Read-side scheduler for the byte-to-word packing FIFO: watches the FIFO fill level and drains it toward downstream in bounded bursts. It issues a full burst once enough words are queued, and flushes a partial burst after an idle timeout. It also marks each burst with sop/eop for the downstream framer. It sits in the FIFO read clock domain, between the FIFO read port and the 32-bit consumer.

---
 rtl/fifo_ctrl_pkg.sv | 13 +
 rtl/fifo_idle_timer.sv | 41 ++++
 rtl/fifo_burst_rd_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the byte-to-word FIFO read/write controllers.
package fifo_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_idle_timer.sv
// Saturating idle counter with synchronous clear; tc rises the cycle after the count reaches LIMIT.
module fifo_idle_timer #(
  parameter int unsigned LIMIT = 254
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = tc_q;
    if (clr) begin
      cnt_d = '0;
      tc_d  = 1'b0;
    end else if (en) begin
      tc_d = (cnt_q == CW'(LIMIT));
      if (cnt_q != CW'(LIMIT)) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc = tc_q;

endmodule

// File: rtl/fifo_burst_rd_ctrl.sv
// FIFO read-side burst scheduler: full bursts at BURST_LEN words, partial flush after an idle
// timeout when FLUSH_TIMEOUT_EN is defined, with sop/eop framing toward downstream.
module fifo_burst_rd_ctrl #(
  parameter int unsigned DATA_W    = fifo_ctrl_pkg::DATA_W,
  parameter int unsigned CNT_W     = fifo_ctrl_pkg::CNT_W,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  rdusedw,
  input  logic              rdempty,
  input  logic [DATA_W-1:0] q,
  output logic              rdreq,
  input  logic              b_rdy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_vld,
  output logic              sop,
  output logic              eop
);

  import fifo_ctrl_pkg::*;

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              vld_q, vld_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              rdreq_c;
  logic              last_beat_c;
  logic              flush_c;

`ifdef FLUSH_TIMEOUT_EN
  logic timer_tc;

  fifo_idle_timer #(
    .LIMIT ((TIMEOUT > 0) ? TIMEOUT - 1 : 0)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rdempty || (state_q != IDLE)),
    .en    (!rdempty),
    .tc    (timer_tc)
  );

  assign flush_c = timer_tc && !rdempty && (rdusedw != '0);
`else
  assign flush_c = 1'b0;
`endif

  assign last_beat_c = (beat_q == len_q - CNT_W'(1));

  // Next-state, beat/gap counters and read request.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    gap_d   = gap_q;
    rdreq_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        gap_d  = '0;
        if (rdusedw >= CNT_W'(BURST_LEN)) begin
          state_d = BURST;
          len_d   = CNT_W'(BURST_LEN);
        end else if (flush_c) begin
          state_d = BURST;
          len_d   = rdusedw;
        end
      end
      BURST: begin
        rdreq_c = b_rdy && !rdempty;
        if (rdreq_c) begin
          if (last_beat_c) begin
            state_d = GAP;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Framing flags travel with the read request so they line up with the returning word.
  always_comb begin
    vld_d  = rdreq_c;
    sop_d  = rdreq_c && (beat_q == '0);
    eop_d  = rdreq_c && last_beat_c;
    hold_d = vld_q ? q : hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      hold_q  <= hold_d;
    end
  end

  // q is the FIFO's registered read port, so it is forwarded in the valid cycle and held otherwise.
  assign rdreq        = rdreq_c;
  assign data_out     = vld_q ? q : hold_q;
  assign data_out_vld = vld_q;
  assign sop          = sop_q;
  assign eop          = eop_q;

endmodule
